// File: rtl/picoblaze_int_ctrl.sv
// ---------------------------------------------------------------------------
// picoblaze_int_ctrl
//   Interrupt controller for the basic Picoblaze system. Latches up to
//   NUM_SRC rising-edge requests, prioritises them (lowest index wins) and
//   drives the processor interrupt line with the interrupt/interrupt_ack
//   handshake. Registers sit on the Picoblaze I/O port bus:
//     BASE_PORT+0 PENDING  R, write-1-to-clear
//     BASE_PORT+1 MASK     R/W, 1 = enabled
//     BASE_PORT+2 ACTIVE   R, bit7 valid, bits2:0 index; any write = EOI
//     BASE_PORT+3 CONTROL  bit0 GIE R/W, bit1 TIMEOUT R/W1C
//
// Ports:
//   CLK_IN            system clock (rising edge)
//   RESET_N_IN        synchronous active-low reset
//   IRQ_IN            request lines (synchronous), rising edge = request
//   PORT_ID_IN        Picoblaze port_id
//   OUT_PORT_IN       Picoblaze out_port
//   WRITE_STROBE_IN   Picoblaze write_strobe
//   READ_STROBE_IN    Picoblaze read_strobe (reads have no side effects)
//   IN_PORT_OUT       registered read data, 0 when port_id not decoded
//   INTERRUPT_OUT     to Picoblaze interrupt
//   INTERRUPT_ACK_IN  from Picoblaze interrupt_ack
//
// Optional feature: define INT_CTRL_TIMEOUT_EN to drop an unacknowledged
// interrupt after TIMEOUT_CYCLES and set the sticky CONTROL.TIMEOUT flag.
// ---------------------------------------------------------------------------
module picoblaze_int_ctrl #(
    parameter int          NUM_SRC        = 8,
    parameter logic [7:0]  BASE_PORT      = 8'hF0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic               CLK_IN,
    input  logic               RESET_N_IN,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    input  logic [7:0]         PORT_ID_IN,
    input  logic [7:0]         OUT_PORT_IN,
    input  logic               WRITE_STROBE_IN,
    input  logic               READ_STROBE_IN,
    output logic [7:0]         IN_PORT_OUT,
    output logic               INTERRUPT_OUT,
    input  logic               INTERRUPT_ACK_IN
);

    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] irq_prev, pending, mask, pend_next;
    logic [NUM_SRC-1:0] rise, eligible, first_hot;
    logic               gie, tflag, active_valid, any_elig, take_ack;
    logic [2:0]         active_idx, idx;
    logic [7:0]         offs, rd_data, pend8, mask8;
    logic               decoded, wr_pend, wr_mask, wr_eoi, wr_ctrl;
    logic               unused_sigs;

    assign unused_sigs = READ_STROBE_IN ^ (TIMEOUT_CYCLES == 0);

    assign rise     = IRQ_IN & ~irq_prev;
    assign eligible = gie ? (pending & mask) : '0;
    assign any_elig = |eligible;
    assign take_ack = (state == ASSERT) && INTERRUPT_ACK_IN && any_elig;

    // Decode by offset so BASE_PORT need not be 4-aligned.
    assign offs    = PORT_ID_IN - BASE_PORT;
    assign decoded = (offs < 8'd4);
    assign wr_pend = WRITE_STROBE_IN && decoded && (offs[1:0] == 2'd0);
    assign wr_mask = WRITE_STROBE_IN && decoded && (offs[1:0] == 2'd1);
    assign wr_eoi  = WRITE_STROBE_IN && decoded && (offs[1:0] == 2'd2);
    assign wr_ctrl = WRITE_STROBE_IN && decoded && (offs[1:0] == 2'd3);

    // Lowest eligible index, plus its one-hot for the ack-time clear.
    always_comb begin
        idx       = '0;
        first_hot = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (first_hot == '0)) begin
                idx          = 3'(i);
                first_hot[i] = 1'b1;
            end
        end
    end

    // A rise in the same cycle as a clear keeps the bit set.
    always_comb begin
        pend_next = pending;
        if (wr_pend)
            pend_next = pend_next & ~OUT_PORT_IN[NUM_SRC-1:0];
        if (take_ack)
            pend_next = pend_next & ~first_hot;
        pend_next = pend_next | rise;
    end

    always_comb begin
        pend8 = '0;
        mask8 = '0;
        pend8[NUM_SRC-1:0] = pending;
        mask8[NUM_SRC-1:0] = mask;
        rd_data = '0;
        if (decoded) begin
            case (offs[1:0])
                2'd0:    rd_data = pend8;
                2'd1:    rd_data = mask8;
                2'd2:    rd_data = {active_valid, 4'b0000, active_idx};
                default: rd_data = {6'b000000, tflag, gie};
            endcase
        end
    end

`ifdef INT_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tcnt;
    logic          tmo;
    assign tmo = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tflag = 1'b0;
`endif

    always_ff @(posedge CLK_IN) begin
        irq_prev <= IRQ_IN;
        if (!RESET_N_IN) begin
            state         <= IDLE;
            pending       <= '0;
            mask          <= '0;
            gie           <= 1'b0;
            active_valid  <= 1'b0;
            active_idx    <= '0;
            IN_PORT_OUT   <= '0;
            INTERRUPT_OUT <= 1'b0;
`ifdef INT_CTRL_TIMEOUT_EN
            tflag         <= 1'b0;
            tcnt          <= '0;
`endif
        end else begin
            IN_PORT_OUT <= rd_data;
            pending     <= pend_next;
            if (wr_mask)
                mask <= OUT_PORT_IN[NUM_SRC-1:0];
            if (wr_ctrl)
                gie <= OUT_PORT_IN[0];
`ifdef INT_CTRL_TIMEOUT_EN
            if (wr_ctrl && OUT_PORT_IN[1])
                tflag <= 1'b0;
`endif
            if (wr_eoi) begin
                active_valid <= 1'b0;
                active_idx   <= '0;
            end
            case (state)
                IDLE: begin
                    if (any_elig && !active_valid) begin
                        state         <= ASSERT;
                        INTERRUPT_OUT <= 1'b1;
`ifdef INT_CTRL_TIMEOUT_EN
                        tcnt          <= '0;
`endif
                    end
                end
                ASSERT: begin
                    if (!any_elig) begin
                        state         <= IDLE;
                        INTERRUPT_OUT <= 1'b0;
                    end else if (INTERRUPT_ACK_IN) begin
                        state         <= SERVICE;
                        INTERRUPT_OUT <= 1'b0;
                        active_valid  <= 1'b1;
                        active_idx    <= idx;
                    end
`ifdef INT_CTRL_TIMEOUT_EN
                    else if (tmo) begin
                        state         <= IDLE;
                        INTERRUPT_OUT <= 1'b0;
                        tflag         <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                default: begin
                    if (wr_eoi)
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picoblaze_int_ctrl.sv
module tb_picoblaze_int_ctrl;

    localparam logic [7:0] BASE = 8'hF0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq = 8'h00;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       ws = 1'b0;
    logic       rs = 1'b0;
    logic [7:0] in_port;
    logic       intr;
    logic       ack = 1'b0;

    int nvec = 0;
    int nerr = 0;

    picoblaze_int_ctrl #(.NUM_SRC(8), .BASE_PORT(BASE), .TIMEOUT_CYCLES(16)) dut (
        .CLK_IN(clk), .RESET_N_IN(rst_n), .IRQ_IN(irq), .PORT_ID_IN(port_id),
        .OUT_PORT_IN(out_port), .WRITE_STROBE_IN(ws), .READ_STROBE_IN(rs),
        .IN_PORT_OUT(in_port), .INTERRUPT_OUT(intr), .INTERRUPT_ACK_IN(ack)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] o, input logic [7:0] d);
        port_id = BASE + 8'(o); out_port = d; ws = 1'b1;
        tick();
        ws = 1'b0; port_id = 8'h00;
    endtask

    task automatic rd_reg(input logic [1:0] o, output logic [7:0] d);
        port_id = BASE + 8'(o); rs = 1'b1;
        tick();
        d = in_port;
        rs = 1'b0; port_id = 8'h00;
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq = irq | m;
        tick();
        irq = irq & ~m;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        irq = 8'h01; rst_n = 1'b0;
        tick(); tick(); tick();
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL reset_int got %b want 0", intr); end
        nvec++; if (in_port !== 8'h00) begin nerr++; $display("FAIL reset_inport got %h want 00", in_port); end
        rst_n = 1'b1;
        tick();
        wr_reg(2'd1, 8'h01);
        wr_reg(2'd3, 8'h01);
        rd_reg(2'd0, d);
        nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL reset_noedge_pend got %h want 00", d); end
        tick(); tick();
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL reset_noedge_int got %b want 0", intr); end
        rd_reg(2'd3, d);
        nvec++; if (d !== 8'h01) begin nerr++; $display("FAIL reset_ctrl got %h want 01", d); end
        irq = 8'h00;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] d;
        wr_reg(2'd1, 8'hFF);
        pulse_irq(8'h20);
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL single_int_early got %b want 0", intr); end
        tick();
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL single_int_assert got %b want 1", intr); end
        rd_reg(2'd0, d);
        nvec++; if (d !== 8'h20) begin nerr++; $display("FAIL single_pend got %h want 20", d); end
        ack = 1'b1; tick(); ack = 1'b0;
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL single_int_ack got %b want 0", intr); end
        rd_reg(2'd2, d);
        nvec++; if (d !== 8'h85) begin nerr++; $display("FAIL single_active got %h want 85", d); end
        rd_reg(2'd0, d);
        nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL single_pend_clr got %h want 00", d); end
        wr_reg(2'd2, 8'h00);
        rd_reg(2'd2, d);
        nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL single_eoi got %h want 00", d); end
    endtask

    task automatic test_priority();
        logic [7:0] d;
        pulse_irq(8'h44);
        tick();
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL prio_int got %b want 1", intr); end
        ack = 1'b1; tick(); ack = 1'b0;
        rd_reg(2'd2, d);
        nvec++; if (d !== 8'h82) begin nerr++; $display("FAIL prio_active1 got %h want 82", d); end
        rd_reg(2'd0, d);
        nvec++; if (d !== 8'h40) begin nerr++; $display("FAIL prio_pend got %h want 40", d); end
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL prio_service_int got %b want 0", intr); end
        wr_reg(2'd2, 8'h00);
        tick();
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL prio_reassert got %b want 1", intr); end
        ack = 1'b1; tick(); ack = 1'b0;
        rd_reg(2'd2, d);
        nvec++; if (d !== 8'h86) begin nerr++; $display("FAIL prio_active2 got %h want 86", d); end
        wr_reg(2'd2, 8'h00);
        rd_reg(2'd0, d);
        nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL prio_pend_end got %h want 00", d); end
    endtask

    task automatic test_mask();
        logic [7:0] d;
        wr_reg(2'd1, 8'h00);
        pulse_irq(8'h08);
        tick(); tick();
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL mask_noint got %b want 0", intr); end
        rd_reg(2'd0, d);
        nvec++; if (d !== 8'h08) begin nerr++; $display("FAIL mask_pend got %h want 08", d); end
        wr_reg(2'd1, 8'h08);
        tick();
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL mask_enable_int got %b want 1", intr); end
        wr_reg(2'd0, 8'h08);
        // Ack arriving together with eligible=0 must be ignored.
        ack = 1'b1; tick(); ack = 1'b0;
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL mask_withdraw_int got %b want 0", intr); end
        rd_reg(2'd2, d);
        nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL mask_active got %h want 00", d); end
        tick();
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL mask_idle_int got %b want 0", intr); end
    endtask

    task automatic test_set_wins();
        logic [7:0] d;
        wr_reg(2'd1, 8'h00);
        port_id = BASE; out_port = 8'h10; ws = 1'b1; irq = 8'h10;
        tick();
        ws = 1'b0; port_id = 8'h00; irq = 8'h00;
        rd_reg(2'd0, d);
        nvec++; if (d !== 8'h10) begin nerr++; $display("FAIL setwins_pend got %h want 10", d); end
        wr_reg(2'd0, 8'h10);
        rd_reg(2'd0, d);
        nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL w1c_pend got %h want 00", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        wr_reg(2'd1, 8'hFF);
        pulse_irq(8'h02);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        pulse_irq(8'h80);
        rd_reg(2'd2, d);
        nvec++; if (d !== 8'h81) begin nerr++; $display("FAIL mid_active got %h want 81", d); end
        port_id = BASE + 8'd2;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL mid_int got %b want 0", intr); end
        nvec++; if (in_port !== 8'h00) begin nerr++; $display("FAIL mid_inport got %h want 00", in_port); end
        rd_reg(2'd0, d);
        nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL mid_pend got %h want 00", d); end
        rd_reg(2'd1, d);
        nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL mid_mask got %h want 00", d); end
        rd_reg(2'd2, d);
        nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL mid_active_clr got %h want 00", d); end
        rd_reg(2'd3, d);
        nvec++; if (d !== 8'h00) begin nerr++; $display("FAIL mid_ctrl got %h want 00", d); end
    endtask

`ifdef INT_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] d;
        wr_reg(2'd1, 8'h01);
        wr_reg(2'd3, 8'h01);
        pulse_irq(8'h01);
        tick();
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL tmo_int_start got %b want 1", intr); end
        for (int i = 0; i < 15; i++) tick();
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL tmo_int_16th got %b want 1", intr); end
        tick();
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL tmo_int_drop got %b want 0", intr); end
        rd_reg(2'd3, d);
        nvec++; if (d !== 8'h03) begin nerr++; $display("FAIL tmo_ctrl got %h want 03", d); end
        wr_reg(2'd3, 8'h03);
        rd_reg(2'd3, d);
        nvec++; if (d !== 8'h01) begin nerr++; $display("FAIL tmo_ctrl_clr got %h want 01", d); end
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL tmo_reassert got %b want 1", intr); end
        ack = 1'b1; tick(); ack = 1'b0;
        wr_reg(2'd2, 8'h00);
    endtask
`else
    task automatic test_control();
        logic [7:0] d;
        wr_reg(2'd3, 8'h03);
        rd_reg(2'd3, d);
        nvec++; if (d !== 8'h01) begin nerr++; $display("FAIL ctrl_notmo got %h want 01", d); end
        wr_reg(2'd1, 8'h01);
        pulse_irq(8'h01);
        for (int i = 0; i < 40; i++) tick();
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL ctrl_wait got %b want 1", intr); end
        ack = 1'b1; tick(); ack = 1'b0;
        rd_reg(2'd2, d);
        nvec++; if (d !== 8'h80) begin nerr++; $display("FAIL ctrl_active got %h want 80", d); end
        wr_reg(2'd2, 8'h00);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_set_wins();
        test_reset_mid();
`ifdef INT_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_control();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
